// File: rtl/serial_state_rx_if.sv
// Link between the state serializer and serial_state_rx, plus the parallel
// state outputs seen by the consumer side.
interface serial_state_rx_if #(
    parameter int WIDTH = 4
);
    logic             ser_valid;
    logic             ser_data;
    logic [WIDTH-1:0] state_out;
    logic             state_valid;
    logic             frame_done;
    logic             frame_abort;
    logic             busy;

    modport master (
        output ser_valid, ser_data,
        input  state_out, state_valid, frame_done, frame_abort, busy
    );

    modport slave (
        input  ser_valid, ser_data,
        output state_out, state_valid, frame_done, frame_abort, busy
    );
endinterface

// File: rtl/serial_state_rx.sv
// Deserializes LSB-first WIDTH-bit frames and publishes a value only after
// CONFIRM consecutive identical frames.
module serial_state_rx #(
    parameter int WIDTH   = 4,
    parameter int CONFIRM = 2
) (
    input  logic              clk,
    input  logic              reset,
    serial_state_rx_if.slave  bus
);
    localparam int               IDX_W    = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [3:0]       CONF     = 4'(CONFIRM);

    typedef enum logic { IDLE, SHIFT } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [WIDTH-1:0]   cand_q, cand_d;
    logic [3:0]         run_q, run_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic               abort_q, abort_d;

    logic [WIDTH-1:0]   frame_val;
    logic               match;
    logic [3:0]         run_inc;

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        cand_d    = cand_q;
        run_d     = run_q;
        out_d     = out_q;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        abort_d   = 1'b0;

        // Frame value as it will look once the current bit lands.
        frame_val            = shift_q;
        frame_val[bit_idx_q] = bus.ser_data;
        match   = (run_q != 4'd0) && (frame_val == cand_q);
        run_inc = (run_q >= CONF) ? CONF : run_q + 4'd1;

        case (state_q)
            IDLE: begin
                if (bus.ser_valid) begin
                    shift_d[0] = bus.ser_data;
                    bit_idx_d  = IDX_W'(1);
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.ser_valid) begin
                    shift_d = frame_val;
                    if (bit_idx_q == LAST_IDX) begin
                        bit_idx_d = '0;
                        done_d    = 1'b1;
                        if (match) begin
                            run_d = run_inc;
                        end else begin
                            cand_d = frame_val;
                            run_d  = 4'd1;
                        end
                        // A fresh run counts as starting from zero, so
                        // CONFIRM=1 publishes every changed value.
                        if (run_d == CONF && (!match || run_q < CONF)) begin
                            out_d   = frame_val;
                            valid_d = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end else begin
                    abort_d   = (bit_idx_q != '0);
                    bit_idx_d = '0;
                    run_d     = 4'd0;
                    state_d   = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_idx_q <= '0;
            shift_q   <= '0;
            cand_q    <= '0;
            run_q     <= 4'd0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            cand_q    <= cand_d;
            run_q     <= run_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
        end
    end

    assign bus.state_out   = out_q;
    assign bus.state_valid = valid_q;
    assign bus.frame_done  = done_q;
    assign bus.frame_abort = abort_q;
    assign bus.busy        = (state_q == SHIFT);
endmodule
